sel_encode_sb: RTL

- Parametrised, registered successor to the mini_cpu register select/encode stage.
- Holds the instruction register (IR) and extracts opcode, ra/rb/rc and the sign-extended C field.
- Drives one-hot register in/out strobes for NUM_REGS registers, one cycle after the control strobes.
- Adds a per-register busy scoreboard with a stall output, deterministic field priority, and R0-as-zero handling for BAout.
- Sits between the control unit and the register file / bus.

---
 rtl/sel_encode_pkg.sv | 28 ++
 rtl/sel_encode_sb_onehot_dec.sv | 19 +
 rtl/sel_encode_sb.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sel_encode_pkg.sv
// rtl/sel_encode_pkg.sv - shared constants, field offsets and select type for sel_encode_sb
package sel_encode_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_OPCODE_W = 5;

    // Register fields sit directly below the opcode: ra, then rb, then rc
    function automatic int ra_lsb(input int data_w, input int opcode_w, input int idx_w);
        return data_w - opcode_w - idx_w;
    endfunction

    function automatic int rb_lsb(input int data_w, input int opcode_w, input int idx_w);
        return ra_lsb(data_w, opcode_w, idx_w) - idx_w;
    endfunction

    function automatic int rc_lsb(input int data_w, input int opcode_w, input int idx_w);
        return rb_lsb(data_w, opcode_w, idx_w) - idx_w;
    endfunction

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_A,
        SEL_B,
        SEL_C
    } sel_t;

endpackage

// File: rtl/sel_encode_sb_onehot_dec.sv
// rtl/sel_encode_sb_onehot_dec.sv - enabled index to one-hot decoder
module onehot_dec #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic [IDX_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // Single hot bit at idx when enabled, all zero otherwise
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sel_encode_sb.sv
// rtl/sel_encode_sb.sv - IR decode, registered register strobes and busy scoreboard (option: SEL_ENCODE_SB_MULTISEL_CHK_EN)
module sel_encode_sb
    import sel_encode_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int IDX_W    = $clog2(NUM_REGS),
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int C_W      = DATA_W - OPCODE_W - 2*IDX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   ir_in,
    input  logic                ir_ld,
    input  logic                gra,
    input  logic                grb,
    input  logic                grc,
    input  logic                rin,
    input  logic                rout,
    input  logic                baout,
    input  logic                sb_set,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_idx,
    output logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   c_sign_ext,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic [IDX_W-1:0]    sel_idx,
    output logic                base_zero,
    output logic                stall,
`ifdef SEL_ENCODE_SB_MULTISEL_CHK_EN
    output logic                multisel_err,
`endif
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam int RA_LSB = ra_lsb(DATA_W, OPCODE_W, IDX_W);
    localparam int RB_LSB = rb_lsb(DATA_W, OPCODE_W, IDX_W);
    localparam int RC_LSB = rc_lsb(DATA_W, OPCODE_W, IDX_W);

    logic [DATA_W-1:0]   ir;
    logic [NUM_REGS-1:0] busy;
    logic [IDX_W-1:0]    ra, rb, rc, idx;
    sel_t                sel;
    logic                any_sel, go, base_hit, rin_en, rout_en, sb_take;
    logic [NUM_REGS-1:0] rin_vec, rout_vec;

    assign ra = ir[RA_LSB +: IDX_W];
    assign rb = ir[RB_LSB +: IDX_W];
    assign rc = ir[RC_LSB +: IDX_W];

    assign opcode     = ir[DATA_W-1 -: OPCODE_W];
    assign c_sign_ext = {{(DATA_W-C_W){ir[C_W-1]}}, ir[C_W-1:0]};

    // Fixed field priority gra > grb > grc; nothing selected decodes to index 0
    always_comb begin
        sel = SEL_NONE;
        idx = '0;
        if (gra) begin
            sel = SEL_A;
            idx = ra;
        end else if (grb) begin
            sel = SEL_B;
            idx = rb;
        end else if (grc) begin
            sel = SEL_C;
            idx = rc;
        end
    end

    assign any_sel = (sel != SEL_NONE);

    // Reading a register still owed a writeback must wait; ra only matters when it is read
    assign stall = (grb & busy[rb])
                 | (grc & ~grb & busy[rc])
                 | (gra & (rout | baout) & busy[ra]);

    assign go       = any_sel & ~stall;
    assign base_hit = go & baout & (idx == '0);
    assign rin_en   = go & rin;
    assign rout_en  = go & (rout | baout) & ~base_hit;
    assign sb_take  = sb_set & gra & ~stall;

    onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rin_dec (
        .idx    (idx),
        .en     (rin_en),
        .onehot (rin_vec)
    );

    onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_rout_dec (
        .idx    (idx),
        .en     (rout_en),
        .onehot (rout_vec)
    );

    // Instruction register and the one-cycle-delayed strobe outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir        <= '0;
            sel_idx   <= '0;
            r_in      <= '0;
            r_out     <= '0;
            base_zero <= 1'b0;
        end else begin
            if (ir_ld) begin
                ir <= ir_in;
            end
            sel_idx   <= idx;
            r_in      <= rin_vec;
            r_out     <= rout_vec;
            base_zero <= base_hit;
        end
    end

    // Busy scoreboard: a set in the same cycle as a retire of that register wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sb_take && (ra == IDX_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wb_valid && (wb_idx == IDX_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy;

`ifdef SEL_ENCODE_SB_MULTISEL_CHK_EN
    logic multisel_q;

    // Sticky flag for ambiguous control: several field selects, or write and read together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multisel_q <= 1'b0;
        end else if ((gra & grb) | (gra & grc) | (grb & grc) | (rin & rout)) begin
            multisel_q <= 1'b1;
        end
    end

    assign multisel_err = multisel_q;
`endif

endmodule
